text_console_writer: RTL and testbench

Upstream feeder for the VGA text-mode display. Accepts a stream of ASCII bytes over a valid/ready handshake and maintains a cursor. It writes characters into the write port of the 100×75 text buffer, whose read port is scanned by the pixel pipeline. It handles newline, carriage return, backspace and form feed, and clears the buffer with hardware fill sequences.

---
 rtl/text_console_writer_pkg.sv | 24 ++
 rtl/text_cursor.sv | 62 ++++++
 rtl/text_console_writer.sv | 186 ++++++++++++++++++
 tb/tb_text_console_writer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_console_writer_pkg.sv
// rtl/text_console_writer_pkg.sv - shared text display geometry, character codes and writer states
package text_console_writer_pkg;

  localparam int COLS   = 100;
  localparam int ROWS   = 75;
  localparam int ADDR_W = 13;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_FF    = 8'h0C;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CLR_LINE   = 2'd1,
    ST_CLR_SCREEN = 2'd2
  } state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_cursor.sv
// rtl/text_cursor.sv - cursor column/row and row base address (row*COLS) without a multiplier
module text_cursor #(
  parameter int COLS   = 100,
  parameter int ROWS   = 75,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_advance,
  input  logic              i_newline,
  input  logic              i_carriage_return,
  input  logic              i_back,
  input  logic              i_home,
  output logic [6:0]        o_col,
  output logic [6:0]        o_row,
  output logic [ADDR_W-1:0] o_row_base
);

  localparam logic [6:0]        LP_COL_LAST = 7'(COLS - 1);
  localparam logic [6:0]        LP_ROW_LAST = 7'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LP_STRIDE   = ADDR_W'(COLS);

  logic [6:0]        r_col;
  logic [6:0]        r_row;
  logic [ADDR_W-1:0] r_row_base;
  logic              w_row_adv;

  // A printable in the last column behaves like a newline after its write.
  assign w_row_adv = i_newline || (i_advance && (r_col == LP_COL_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col      <= '0;
      r_row      <= '0;
      r_row_base <= '0;
    end else if (i_home) begin
      r_col      <= '0;
      r_row      <= '0;
      r_row_base <= '0;
    end else if (w_row_adv) begin
      r_col <= '0;
      if (r_row == LP_ROW_LAST) begin
        r_row      <= '0;
        r_row_base <= '0;
      end else begin
        r_row      <= r_row + 7'd1;
        r_row_base <= r_row_base + LP_STRIDE;
      end
    end else if (i_advance) begin
      r_col <= r_col + 7'd1;
    end else if (i_carriage_return) begin
      r_col <= '0;
    end else if (i_back && (r_col != 7'd0)) begin
      r_col <= r_col - 7'd1;
    end
  end

  assign o_col      = r_col;
  assign o_row      = r_row;
  assign o_row_base = r_row_base;

endmodule

// File: rtl/text_console_writer.sv
// rtl/text_console_writer.sv - ASCII byte stream to text buffer write port with cursor and hardware clears
module text_console_writer #(
  parameter int COLS           = text_console_writer_pkg::COLS,
  parameter int ROWS           = text_console_writer_pkg::ROWS,
  parameter int ADDR_W         = text_console_writer_pkg::ADDR_W,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_char,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [6:0]        cursor_col,
  output logic [6:0]        cursor_row,
  output logic              busy
);

  import text_console_writer_pkg::*;

  localparam logic [6:0]        LP_COL_LAST    = 7'(COLS - 1);
  localparam logic [ADDR_W-1:0] LP_LINE_LAST   = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] LP_SCREEN_LAST = ADDR_W'(COLS * ROWS - 1);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic              r_started;
  logic              r_in_ready, w_in_ready_nxt;
  logic              r_wr_en, w_wr_en_nxt;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [7:0]        r_wr_data, w_wr_data_nxt;

  logic              w_accept;
  logic              w_advance, w_newline, w_cr, w_back, w_home;
  logic [6:0]        w_col, w_row;
  logic [ADDR_W-1:0] w_row_base, w_cur_addr;

  assign w_accept   = in_valid && r_in_ready;
  assign w_cur_addr = w_row_base + ADDR_W'(w_col);

  text_cursor #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_cursor (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_advance         (w_advance),
    .i_newline         (w_newline),
    .i_carriage_return (w_cr),
    .i_back            (w_back),
    .i_home            (w_home),
    .o_col             (w_col),
    .o_row             (w_row),
    .o_row_base        (w_row_base)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_in_ready_nxt = r_in_ready;
    w_wr_en_nxt    = 1'b0;
    w_wr_addr_nxt  = r_wr_addr;
    w_wr_data_nxt  = r_wr_data;
    w_advance      = 1'b0;
    w_newline      = 1'b0;
    w_cr           = 1'b0;
    w_back         = 1'b0;
    w_home         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!r_started) begin
          // First clock after reset release: either open for input or launch the screen clear.
          if (CLEAR_ON_RESET) begin
            w_state_nxt   = ST_CLR_SCREEN;
            w_wr_en_nxt   = 1'b1;
            w_wr_addr_nxt = '0;
            w_wr_data_nxt = CHAR_SPACE;
            w_cnt_nxt     = ADDR_W'(1);
          end else begin
            w_in_ready_nxt = 1'b1;
          end
        end else if (w_accept) begin
          if (is_printable(in_char)) begin
            w_wr_en_nxt   = 1'b1;
            w_wr_addr_nxt = w_cur_addr;
            w_wr_data_nxt = in_char;
            w_advance     = 1'b1;
            if (w_col == LP_COL_LAST) begin
              w_state_nxt    = ST_CLR_LINE;
              w_cnt_nxt      = '0;
              w_in_ready_nxt = 1'b0;
            end
          end else begin
            case (in_char)
              CHAR_LF: begin
                w_newline      = 1'b1;
                w_state_nxt    = ST_CLR_LINE;
                w_cnt_nxt      = '0;
                w_in_ready_nxt = 1'b0;
              end
              CHAR_CR: w_cr = 1'b1;
              CHAR_BS: begin
                if (w_col != 7'd0) begin
                  w_back        = 1'b1;
                  w_wr_en_nxt   = 1'b1;
                  w_wr_addr_nxt = w_cur_addr - ADDR_W'(1);
                  w_wr_data_nxt = CHAR_SPACE;
                end
              end
              CHAR_FF: begin
                // The first fill write issues alongside the FF acceptance.
                w_home         = 1'b1;
                w_state_nxt    = ST_CLR_SCREEN;
                w_wr_en_nxt    = 1'b1;
                w_wr_addr_nxt  = '0;
                w_wr_data_nxt  = CHAR_SPACE;
                w_cnt_nxt      = ADDR_W'(1);
                w_in_ready_nxt = 1'b0;
              end
              default: ;
            endcase
          end
        end
      end

      ST_CLR_LINE: begin
        w_wr_en_nxt   = 1'b1;
        w_wr_addr_nxt = w_row_base + r_cnt;
        w_wr_data_nxt = CHAR_SPACE;
        if (r_cnt == LP_LINE_LAST) begin
          w_state_nxt    = ST_IDLE;
          w_in_ready_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_W'(1);
        end
      end

      ST_CLR_SCREEN: begin
        w_wr_en_nxt   = 1'b1;
        w_wr_addr_nxt = r_cnt;
        w_wr_data_nxt = CHAR_SPACE;
        if (r_cnt == LP_SCREEN_LAST) begin
          w_state_nxt    = ST_IDLE;
          w_in_ready_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_W'(1);
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_started  <= 1'b0;
      r_in_ready <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_started  <= 1'b1;
      r_in_ready <= w_in_ready_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_wr_data  <= w_wr_data_nxt;
    end
  end

  assign in_ready   = r_in_ready;
  assign busy       = !r_in_ready;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign cursor_col = w_col;
  assign cursor_row = w_row;

endmodule

// File: tb/tb_text_console_writer.sv
// tb/tb_text_console_writer.sv - table, directed and randomized checks of text_console_writer against a screen model
module tb_text_console_writer;

  localparam int COLS   = 100;
  localparam int ROWS   = 75;
  localparam int ADDR_W = 13;
  localparam int CELLS  = COLS * ROWS;
  localparam int WAIT_MAX = 20000;

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_char  = 8'h00;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [6:0]        cursor_col;
  logic [6:0]        cursor_row;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] dut_screen [CELLS];
  logic [7:0] ref_screen [CELLS];
  int ref_col = 0;
  int ref_row = 0;

  typedef struct {
    logic [7:0] c;
    int         col;
    int         row;
    bit         wr;
    int         addr;
    logic [7:0] data;
  } vec_t;
  vec_t vecs [11];

  always #5 clk = ~clk;

  text_console_writer #(
    .COLS           (COLS),
    .ROWS           (ROWS),
    .ADDR_W         (ADDR_W),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_char    (in_char),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  // The observed display contents, rebuilt from every write strobe.
  always @(negedge clk) begin
    if (wr_en === 1'b1 && int'(wr_addr) < CELLS) dut_screen[wr_addr] = wr_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CELLS; i++) ref_screen[i] = 8'h20;
    ref_col = 0;
    ref_row = 0;
  endtask

  task automatic model_new_row();
    ref_row = (ref_row + 1) % ROWS;
    for (int i = 0; i < COLS; i++) ref_screen[ref_row * COLS + i] = 8'h20;
  endtask

  task automatic model_apply(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      ref_screen[ref_row * COLS + ref_col] = c;
      if (ref_col == COLS - 1) begin
        ref_col = 0;
        model_new_row();
      end else begin
        ref_col++;
      end
    end else if (c == 8'h0A) begin
      ref_col = 0;
      model_new_row();
    end else if (c == 8'h0D) begin
      ref_col = 0;
    end else if (c == 8'h08) begin
      if (ref_col > 0) begin
        ref_col--;
        ref_screen[ref_row * COLS + ref_col] = 8'h20;
      end
    end else if (c == 8'h0C) begin
      model_reset();
    end
  endtask

  // Called at a falling edge; returns at the falling edge just after the accepting rising edge.
  task automatic send_byte(input logic [7:0] c);
    int n = 0;
    in_valid = 1'b1;
    in_char  = c;
    while (in_ready !== 1'b1 && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
    if (n >= WAIT_MAX) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed low for %0d cycles, required 1 within %0d", n, WAIT_MAX);
    end
    @(negedge clk);
    in_valid = 1'b0;
    model_apply(c);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (in_ready !== 1'b1 && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
    if (n >= WAIT_MAX) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: in_ready stayed low for %0d cycles, required 1", n);
    end
  endtask

  task automatic check_full_clear(input string tag);
    int bad = 0;
    int first_bad = -1;
    for (int i = 0; i < CELLS; i++) begin
      @(negedge clk);
      if (wr_en !== 1'b1 || wr_addr !== 13'(i) || wr_data !== 8'h20 ||
          in_ready !== (i == CELLS - 1)) begin
        if (bad == 0) first_bad = i;
        bad++;
      end
    end
    if (bad != 0) $display("first bad clear cycle %0d", first_bad);
    check({tag, "_clear_bad_cycles"}, bad, 0);
    @(negedge clk);
    check({tag, "_wr_en_after"}, wr_en, 0);
    check({tag, "_ready_after"}, in_ready, 1);
    check({tag, "_col"}, cursor_col, 0);
    check({tag, "_row"}, cursor_row, 0);
  endtask

  task automatic check_line_fill(input string tag, input int base);
    int bad = 0;
    for (int i = 0; i < COLS; i++) begin
      @(negedge clk);
      if (wr_en !== 1'b1 || wr_addr !== 13'(base + i) || wr_data !== 8'h20 ||
          in_ready !== (i == COLS - 1) || busy !== (i != COLS - 1)) bad++;
    end
    check(tag, bad, 0);
  endtask

  task automatic check_screen(input string tag);
    int diff = 0;
    @(negedge clk);
    for (int i = 0; i < CELLS; i++) if (dut_screen[i] !== ref_screen[i]) diff++;
    check(tag, diff, 0);
  endtask

  initial begin
    int n_ff = 0;
    logic [7:0] c;

    vecs[0]  = '{8'h41, 1, 0, 1'b1, 0, 8'h41};
    vecs[1]  = '{8'h42, 2, 0, 1'b1, 1, 8'h42};
    vecs[2]  = '{8'h0D, 0, 0, 1'b0, 0, 8'h00};
    vecs[3]  = '{8'h43, 1, 0, 1'b1, 0, 8'h43};
    vecs[4]  = '{8'h08, 0, 0, 1'b1, 0, 8'h20};
    vecs[5]  = '{8'h08, 0, 0, 1'b0, 0, 8'h00};
    vecs[6]  = '{8'h01, 0, 0, 1'b0, 0, 8'h00};
    vecs[7]  = '{8'h7F, 0, 0, 1'b0, 0, 8'h00};
    vecs[8]  = '{8'h7E, 1, 0, 1'b1, 0, 8'h7E};
    vecs[9]  = '{8'h20, 2, 0, 1'b1, 1, 8'h20};
    vecs[10] = '{8'h80, 2, 0, 1'b0, 0, 8'h00};

    repeat (3) @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 1);
    check("rst_col", cursor_col, 0);
    check("rst_row", cursor_row, 0);

    rst_n = 1'b1;
    model_reset();
    check_full_clear("por");
    check_screen("screen_after_por");

    for (int i = 0; i < 11; i++) begin
      send_byte(vecs[i].c);
      check($sformatf("vec%0d_col", i), cursor_col, vecs[i].col);
      check($sformatf("vec%0d_row", i), cursor_row, vecs[i].row);
      check($sformatf("vec%0d_wr_en", i), wr_en, vecs[i].wr);
      if (vecs[i].wr) begin
        check($sformatf("vec%0d_addr", i), wr_addr, vecs[i].addr);
        check($sformatf("vec%0d_data", i), wr_data, vecs[i].data);
      end
      check($sformatf("vec%0d_ready", i), in_ready, 1);
    end

    // Fill row 0, wrap, and hold the next byte pending through the line clear.
    send_byte(8'h0D);
    for (int i = 0; i < 99; i++) send_byte(8'h30 + 8'(i % 10));
    send_byte(8'h58);
    check("wrap_wr_en", wr_en, 1);
    check("wrap_addr", wr_addr, 99);
    check("wrap_data", wr_data, 8'h58);
    check("wrap_col", cursor_col, 0);
    check("wrap_row", cursor_row, 1);
    check("wrap_ready", in_ready, 0);
    in_valid = 1'b1;
    in_char  = 8'h5A;
    check_line_fill("row1_fill", 100);
    @(negedge clk);
    in_valid = 1'b0;
    model_apply(8'h5A);
    check("stall_wr_addr", wr_addr, 100);
    check("stall_wr_data", wr_data, 8'h5A);
    check("stall_col", cursor_col, 1);
    check("stall_row", cursor_row, 1);

    // LF on the last row wraps to the top and clears row 0.
    send_byte(8'h0D);
    for (int i = 0; i < 73; i++) send_byte(8'h0A);
    check("row74_row", cursor_row, 74);
    send_byte(8'h0A);
    check("lfwrap_col", cursor_col, 0);
    check("lfwrap_row", cursor_row, 0);
    check("lfwrap_no_write", wr_en, 0);
    check("lfwrap_ready", in_ready, 0);
    check_line_fill("lfwrap_fill", 0);

    // Backspace at (5,3) and at (0,3).
    for (int i = 0; i < 3; i++) send_byte(8'h0A);
    for (int i = 0; i < 5; i++) send_byte(8'h61 + 8'(i));
    send_byte(8'h08);
    check("bs_wr_en", wr_en, 1);
    check("bs_addr", wr_addr, 304);
    check("bs_data", wr_data, 8'h20);
    check("bs_col", cursor_col, 4);
    check("bs_row", cursor_row, 3);
    send_byte(8'h0D);
    send_byte(8'h08);
    check("bs0_wr_en", wr_en, 0);
    check("bs0_col", cursor_col, 0);
    check("bs0_row", cursor_row, 3);
    check_screen("screen_directed");

    // Form feed, then reset in the middle of its fill.
    send_byte(8'h71);
    send_byte(8'h0C);
    check("ff_wr_en", wr_en, 1);
    check("ff_addr", wr_addr, 0);
    check("ff_ready", in_ready, 0);
    check("ff_col", cursor_col, 0);
    check("ff_row", cursor_row, 0);
    repeat (40) @(negedge clk);
    check("ff_progress_addr", wr_addr, 40);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_wr_en", wr_en, 0);
    check("midrst_addr", wr_addr, 0);
    check("midrst_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_full_clear("midrst");
    check_screen("screen_after_midrst");

    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 99);
      if (r < 70)      c = 8'($urandom_range(32, 126));
      else if (r < 78) c = 8'h0D;
      else if (r < 88) c = 8'h08;
      else if (r < 95) c = 8'h0A;
      else if (r < 99 || n_ff >= 2) c = 8'($urandom_range(128, 255));
      else begin
        c = 8'h0C;
        n_ff++;
      end
      send_byte(c);
      check($sformatf("rnd%0d_col", i), cursor_col, ref_col);
      check($sformatf("rnd%0d_row", i), cursor_row, ref_row);
    end
    wait_idle();
    check_screen("screen_after_random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
